four_bit_sync_cntr: RTL and testbench

4-bit synchronous binary up-counter built from four T-type flip-flops sharing one clock, with a count enable and a ripple-free carry-out. Intended as a cascadable counter slice: `carry` of one slice drives `cnt_en` of the next. The internal toggle-enable vector is exported for debug and observability.

---
 rtl/four_bit_sync_cntr.sv | 59 +++++
 tb/tb_four_bit_sync_cntr.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/four_bit_sync_cntr.sv
// Cascadable 4-bit synchronous up-counter slice built from T flip-flops.
// carry feeds the next slice's cnt_en; T_in exposes the per-bit toggle enables.

module four_bit_sync_cntr_tff (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

module four_bit_sync_cntr (
  input  logic       rstn,
  input  logic       clk,
  input  logic       cnt_en,
  output logic [3:0] count,
  output logic       carry,
  output logic [3:0] T_in
);

  // and_chain[i] is cnt_en ANDed with every count bit below i; the top tap is the carry.
  logic [4:0] and_chain;

  assign and_chain[0] = cnt_en;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign and_chain[gi+1] = and_chain[gi] & count[gi];

      four_bit_sync_cntr_tff u_tff (
        .clk  (clk),
        .rstn (rstn),
        .t    (and_chain[gi]),
        .q    (count[gi])
      );
    end
  endgenerate

  assign T_in  = and_chain[3:0];
  assign carry = and_chain[4];

endmodule

// File: tb/tb_four_bit_sync_cntr.sv
// Self-checking bench for four_bit_sync_cntr: directed vector table, hand-written
// corner sequences, and randomized enable against an arithmetic reference model.

module tb_four_bit_sync_cntr;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cnt_en;
  logic [3:0] count;
  logic       carry;
  logic [3:0] T_in;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt;

  typedef struct {
    logic       en;
    logic [3:0] cnt;
    logic [3:0] t;
    logic       cy;
  } vec_t;

  vec_t vecs[26];

  four_bit_sync_cntr dut (
    .rstn   (rstn),
    .clk    (clk),
    .cnt_en (cnt_en),
    .count  (count),
    .carry  (carry),
    .T_in   (T_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Bit i toggles when enabled and the value below bit i is all ones (c mod 2^i == 2^i - 1).
  function automatic logic [3:0] model_t(input int c, input bit en);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = en && ((c % (1 << i)) == ((1 << i) - 1));
    end
    return r;
  endfunction

  function automatic logic model_carry(input int c, input bit en);
    return en && (c == 15);
  endfunction

  task automatic set_vec(input int idx, input logic en, input logic [3:0] cnt,
                         input logic [3:0] t, input logic cy);
    vecs[idx] = '{en, cnt, t, cy};
  endtask

  // Called at posedge+1; drives one enable value and checks through the next edge.
  task automatic run_random(input int n, input bit force_en);
    bit en;
    for (int k = 0; k < n; k++) begin
      en = force_en ? 1'b1 : 1'($urandom_range(0, 1));
      cnt_en = en;
      #1;
      check("rnd_t_in", 32'(T_in), 32'(model_t(model_cnt, en)));
      check("rnd_carry", 32'(carry), 32'(model_carry(model_cnt, en)));
      if ($urandom_range(0, 3) == 0) begin
        #2 cnt_en = ~en;
        #1 cnt_en = en;
      end
      @(posedge clk);
      model_cnt = (model_cnt + (en ? 1 : 0)) % 16;
      #1;
      check("rnd_count", 32'(count), 32'(model_cnt));
      $display("rnd edge %0d en=%0b count=%0d", k, en, count);
    end
  endtask

  initial begin
    set_vec( 0, 1'b1, 4'd1,  4'h3, 1'b0);
    set_vec( 1, 1'b1, 4'd2,  4'h1, 1'b0);
    set_vec( 2, 1'b1, 4'd3,  4'h7, 1'b0);
    set_vec( 3, 1'b1, 4'd4,  4'h1, 1'b0);
    set_vec( 4, 1'b1, 4'd5,  4'h3, 1'b0);
    set_vec( 5, 1'b1, 4'd6,  4'h1, 1'b0);
    set_vec( 6, 1'b1, 4'd7,  4'hF, 1'b0);
    set_vec( 7, 1'b1, 4'd8,  4'h1, 1'b0);
    set_vec( 8, 1'b1, 4'd9,  4'h3, 1'b0);
    set_vec( 9, 1'b1, 4'd10, 4'h1, 1'b0);
    set_vec(10, 1'b1, 4'd11, 4'h7, 1'b0);
    set_vec(11, 1'b1, 4'd12, 4'h1, 1'b0);
    set_vec(12, 1'b1, 4'd13, 4'h3, 1'b0);
    set_vec(13, 1'b1, 4'd14, 4'h1, 1'b0);
    set_vec(14, 1'b1, 4'd15, 4'hF, 1'b1);
    set_vec(15, 1'b1, 4'd0,  4'h1, 1'b0);
    set_vec(16, 1'b1, 4'd1,  4'h3, 1'b0);
    set_vec(17, 1'b1, 4'd2,  4'h1, 1'b0);
    set_vec(18, 1'b1, 4'd3,  4'h7, 1'b0);
    set_vec(19, 1'b1, 4'd4,  4'h1, 1'b0);
    set_vec(20, 1'b1, 4'd5,  4'h3, 1'b0);
    set_vec(21, 1'b1, 4'd6,  4'h1, 1'b0);
    set_vec(22, 1'b0, 4'd6,  4'h0, 1'b0);
    set_vec(23, 1'b0, 4'd6,  4'h0, 1'b0);
    set_vec(24, 1'b0, 4'd6,  4'h0, 1'b0);
    set_vec(25, 1'b1, 4'd7,  4'hF, 1'b0);

    rstn   = 1'b0;
    cnt_en = 1'b0;
    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_t_in", 32'(T_in), 32'h0);
    check("reset_carry", 32'(carry), 32'd0);
    #8;
    rstn   = 1'b1;
    cnt_en = 1'b1;
    #2;
    check("release_count", 32'(count), 32'd0);
    check("release_t_in", 32'(T_in), 32'h1);
    check("release_carry", 32'(carry), 32'd0);

    for (int i = 0; i < 26; i++) begin
      cnt_en = vecs[i].en;
      @(posedge clk);
      #1;
      check("vec_count", 32'(count), 32'(vecs[i].cnt));
      check("vec_t_in", 32'(T_in), 32'(vecs[i].t));
      check("vec_carry", 32'(carry), 32'(vecs[i].cy));
      $display("vec %0d en=%0b count=%0d T_in=%h carry=%0b", i, vecs[i].en, count, T_in, carry);
    end

    // Carry gating: reach 15 enabled, then drop the enable.
    cnt_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("gate_count15", 32'(count), 32'd15);
    check("gate_carry_en", 32'(carry), 32'd1);
    cnt_en = 1'b0;
    #1;
    check("gate_carry_dis", 32'(carry), 32'd0);
    check("gate_t_in_dis", 32'(T_in), 32'h0);
    @(posedge clk);
    #1;
    check("gate_hold15", 32'(count), 32'd15);
    $display("carry gating: count=%0d carry=%0b", count, carry);

    // Async reset mid-count at 9.
    cnt_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_count9", 32'(count), 32'd9);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_count", 32'(count), 32'd1);
    $display("async reset: count restarted at %0d", count);

    model_cnt = 1;
    run_random(300, 1'b0);
    run_random(99, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
